// File: rtl/apb_spi_pkg.sv
// Shared register indices, bit positions and the configuration bundle for the
// APB SPI register bank.
package apb_spi_pkg;

  localparam int unsigned REG_CTRL   = 0;
  localparam int unsigned REG_CLKDIV = 1;
  localparam int unsigned REG_TXDATA = 2;
  localparam int unsigned REG_RXDATA = 3;
  localparam int unsigned REG_STATUS = 4;

  localparam int unsigned CTRL_EN     = 0;
  localparam int unsigned CTRL_CPOL   = 1;
  localparam int unsigned CTRL_CPHA   = 2;
  localparam int unsigned CTRL_IRQ_EN = 4;

  localparam int unsigned ST_BUSY    = 0;
  localparam int unsigned ST_TXFULL  = 1;
  localparam int unsigned ST_RXVALID = 2;
  localparam int unsigned ST_OVERRUN = 3;

  localparam int unsigned DIV_W = 16;

  typedef struct packed {
    logic             irq_en;
    logic             cpha;
    logic             cpol;
    logic             en;
    logic [DIV_W-1:0] div;
  } cfg_t;

  // A divider of zero would stall the engine, so it is promoted to one.
  function automatic logic [DIV_W-1:0] div_fix(input logic [DIV_W-1:0] v);
    return (v == '0) ? DIV_W'(1) : v;
  endfunction

endpackage

// File: rtl/apb_spi_flags.sv
// TXFULL / RXVALID / OVERRUN status flags with their set/clear priorities:
// a receive event always beats a read-clear or a W1C in the same cycle.
module apb_spi_flags (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_tx_load,
  input  logic i_tx_hs,
  input  logic i_rx_valid,
  input  logic i_rx_clr,
  input  logic i_ovr_w1c,
  output logic o_txfull,
  output logic o_rxvalid,
  output logic o_overrun
);

  logic r_txfull;
  logic r_rxvalid;
  logic r_overrun;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_txfull  <= 1'b0;
      r_rxvalid <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      // A load is only accepted while empty, so it never meets a handshake.
      if (i_tx_load)    r_txfull <= 1'b1;
      else if (i_tx_hs) r_txfull <= 1'b0;

      if (i_rx_valid)    r_rxvalid <= 1'b1;
      else if (i_rx_clr) r_rxvalid <= 1'b0;

      if (i_rx_valid && r_rxvalid) r_overrun <= 1'b1;
      else if (i_ovr_w1c)          r_overrun <= 1'b0;
    end
  end

  assign o_txfull  = r_txfull;
  assign o_rxvalid = r_rxvalid;
  assign o_overrun = r_overrun;

endmodule

// File: rtl/apb_spi_regs.sv
// APB register bank for the SPI master: configuration, TX/RX holding registers,
// status and slave-error generation. Optional interrupt under APB_SPI_IRQ_EN.
module apb_spi_regs
  import apb_spi_pkg::*;
#(
  parameter int PWIDTH = 32,
  parameter int DWIDTH = 8,
  parameter int REGN   = 5
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic [REGN-1:0]   pselw,
  input  logic              dec_err,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [PWIDTH-1:0] PWDATA,
  output logic [PWIDTH-1:0] PRDATA,
  output logic              PREADY,
  output logic              PSLVERR,
  output logic [DWIDTH-1:0] tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  input  logic [DWIDTH-1:0] rx_data,
  input  logic              rx_valid,
  input  logic              busy,
  output logic              cfg_en,
  output logic              cfg_cpol,
  output logic              cfg_cpha,
  output logic [DIV_W-1:0]  cfg_div,
  output logic              irq
);

  cfg_t              r_cfg;
  logic [DWIDTH-1:0] r_txdata;
  logic [DWIDTH-1:0] r_rxdata;
  logic [PWIDTH-1:0] r_prdata;
  logic              r_rx_wait;

  logic              w_setup;
  logic              w_access;
  logic              w_rx_rd;
  logic              w_pready;
  logic              w_commit;
  logic              w_wr;
  logic              w_tx_load;
  logic              w_rx_clr;
  logic              w_ovr_w1c;
  logic              w_txfull;
  logic              w_rxvalid;
  logic              w_overrun;
  logic [PWIDTH-1:0] w_rdata;
  logic              w_unused;

  assign w_setup  = PSEL & ~PENABLE;
  assign w_access = PSEL & PENABLE;
  assign w_rx_rd  = w_access & ~PWRITE & pselw[REG_RXDATA];
  // RXDATA reads insert exactly one wait state on their first access cycle.
  assign w_pready = ~(w_rx_rd & ~r_rx_wait);
  assign w_commit = w_access & w_pready & ~dec_err;
  assign w_wr     = w_commit & PWRITE;

  assign w_tx_load = w_wr & pselw[REG_TXDATA] & ~w_txfull;
  assign w_rx_clr  = w_commit & ~PWRITE & pselw[REG_RXDATA];
  assign w_ovr_w1c = w_wr & pselw[REG_STATUS] & PWDATA[ST_OVERRUN];

  assign PREADY  = PRESET | w_pready;
  assign PSLVERR = ~PRESET & w_access &
                   (dec_err | (PWRITE & pselw[REG_RXDATA]) |
                    (PWRITE & pselw[REG_TXDATA] & w_txfull));

  always_comb begin
    w_rdata = '0;
    if (pselw[REG_CTRL]) begin
      w_rdata[CTRL_EN]     = r_cfg.en;
      w_rdata[CTRL_CPOL]   = r_cfg.cpol;
      w_rdata[CTRL_CPHA]   = r_cfg.cpha;
      w_rdata[CTRL_IRQ_EN] = r_cfg.irq_en;
    end
    if (pselw[REG_CLKDIV]) w_rdata[DIV_W-1:0]  = r_cfg.div;
    if (pselw[REG_RXDATA]) w_rdata[DWIDTH-1:0] = r_rxdata;
    if (pselw[REG_STATUS]) begin
      w_rdata[ST_BUSY]    = busy;
      w_rdata[ST_TXFULL]  = w_txfull;
      w_rdata[ST_RXVALID] = w_rxvalid;
      w_rdata[ST_OVERRUN] = w_overrun;
    end
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      r_cfg     <= '{irq_en: 1'b0, cpha: 1'b0, cpol: 1'b0, en: 1'b0, div: DIV_W'(1)};
      r_txdata  <= '0;
      r_rxdata  <= '0;
      r_prdata  <= '0;
      r_rx_wait <= 1'b0;
    end else begin
      r_rx_wait <= w_rx_rd & ~r_rx_wait;
      // Read data is captured in setup so it holds through any wait state.
      if (w_setup) r_prdata <= w_rdata;
      if (w_wr && pselw[REG_CTRL]) begin
        r_cfg.en   <= PWDATA[CTRL_EN];
        r_cfg.cpol <= PWDATA[CTRL_CPOL];
        r_cfg.cpha <= PWDATA[CTRL_CPHA];
`ifdef APB_SPI_IRQ_EN
        r_cfg.irq_en <= PWDATA[CTRL_IRQ_EN];
`endif
      end
      if (w_wr && pselw[REG_CLKDIV]) r_cfg.div <= div_fix(PWDATA[DIV_W-1:0]);
      if (w_tx_load) r_txdata <= PWDATA[DWIDTH-1:0];
      if (rx_valid)  r_rxdata <= rx_data;
    end
  end

  apb_spi_flags u_flags (
    .i_clk      (PCLK),
    .i_rst      (PRESET),
    .i_tx_load  (w_tx_load),
    .i_tx_hs    (w_txfull & tx_ready),
    .i_rx_valid (rx_valid),
    .i_rx_clr   (w_rx_clr),
    .i_ovr_w1c  (w_ovr_w1c),
    .o_txfull   (w_txfull),
    .o_rxvalid  (w_rxvalid),
    .o_overrun  (w_overrun)
  );

`ifdef APB_SPI_IRQ_EN
  logic r_irq;
  always_ff @(posedge PCLK) begin
    if (PRESET) r_irq <= 1'b0;
    else        r_irq <= r_cfg.irq_en & (w_rxvalid | w_overrun | ~w_txfull);
  end
  assign irq = r_irq;
`else
  assign irq = 1'b0;
`endif

  assign PRDATA   = r_prdata;
  assign tx_data  = r_txdata;
  assign tx_valid = w_txfull;
  assign cfg_en   = r_cfg.en;
  assign cfg_cpol = r_cfg.cpol;
  assign cfg_cpha = r_cfg.cpha;
  assign cfg_div  = r_cfg.div;

  assign w_unused = ^{PWDATA, pselw};

endmodule

// File: tb/tb_apb_spi_regs.sv
// Self-checking bench for apb_spi_regs; irq expectations follow APB_SPI_IRQ_EN.
module tb_apb_spi_regs;
  localparam int PW = 32;
  localparam int DW = 8;
  localparam int RN = 5;
`ifdef APB_SPI_IRQ_EN
  localparam bit IRQ_FEAT = 1'b1;
`else
  localparam bit IRQ_FEAT = 1'b0;
`endif

  logic          PCLK = 1'b0;
  logic          PRESET = 1'b1;
  logic [RN-1:0] pselw = '0;
  logic          dec_err = 1'b0, PSEL = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0;
  logic [PW-1:0] PWDATA = '0;
  logic [PW-1:0] PRDATA;
  logic          PREADY, PSLVERR;
  logic [DW-1:0] tx_data;
  logic          tx_valid;
  logic          tx_ready = 1'b0;
  logic [DW-1:0] rx_data = '0;
  logic          rx_valid = 1'b0, busy = 1'b0;
  logic          cfg_en, cfg_cpol, cfg_cpha;
  logic [15:0]   cfg_div;
  logic          irq;

  apb_spi_regs #(.PWIDTH(PW), .DWIDTH(DW), .REGN(RN)) dut (
    .PCLK(PCLK), .PRESET(PRESET), .pselw(pselw), .dec_err(dec_err),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PWDATA(PWDATA),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy),
    .cfg_en(cfg_en), .cfg_cpol(cfg_cpol), .cfg_cpha(cfg_cpha),
    .cfg_div(cfg_div), .irq(irq)
  );

  always #5 PCLK = ~PCLK;

  int n_run = 0;
  int n_fail = 0;

  // Behavioural register-file model
  bit          m_en, m_cpol, m_cpha, m_irqen, m_txfull, m_rxv, m_ovr;
  logic [15:0] m_div;
  logic [7:0]  m_tx, m_rx;

  logic [31:0] rd;
  logic        e, es, ea;
  int          w;

  function automatic void model_reset();
    m_en = 0; m_cpol = 0; m_cpha = 0; m_irqen = 0;
    m_txfull = 0; m_rxv = 0; m_ovr = 0;
    m_div = 16'd1; m_tx = 8'h00; m_rx = 8'h00;
  endfunction

  function automatic logic [31:0] model_read(int idx);
    case (idx)
      0: return {27'd0, m_irqen, 1'b0, m_cpha, m_cpol, m_en};
      1: return {16'd0, m_div};
      3: return {24'd0, m_rx};
      4: return {28'd0, m_ovr, m_rxv, m_txfull, busy};
      default: return 32'd0;
    endcase
  endfunction

  function automatic bit model_err(bit wr, int idx);
    return dec_err || (wr && idx == 3) || (wr && idx == 2 && m_txfull);
  endfunction

  function automatic void model_apply(bit wr, int idx, logic [31:0] d, bit rx_last, logic [7:0] rxd);
    bit rxv0;
    rxv0 = m_rxv;
    if (!model_err(wr, idx) && !dec_err) begin
      if (wr) begin
        case (idx)
          0: begin m_en = d[0]; m_cpol = d[1]; m_cpha = d[2]; m_irqen = IRQ_FEAT & d[4]; end
          1: m_div = (d[15:0] == 16'd0) ? 16'd1 : d[15:0];
          2: begin m_tx = d[7:0]; m_txfull = 1; end
          4: if (d[3]) m_ovr = 0;
          default: ;
        endcase
      end else if (idx == 3) m_rxv = 0;
    end
    if (rx_last) begin
      if (rxv0) m_ovr = 1;
      m_rxv = 1;
      m_rx = rxd;
    end
  endfunction

  // One APB transfer; optionally pulses rx_valid in the completing access cycle.
  task automatic apb(input bit wr, input int idx, input logic [31:0] d, input bit rx_last,
                     input logic [7:0] rxd, output logic [31:0] rdata, output logic err,
                     output logic err_setup, output logic err_after, output int waits);
    @(posedge PCLK); #1;
    PSEL = 1; PENABLE = 0; PWRITE = wr; PWDATA = d; pselw = '0;
    if (idx >= 0 && idx < RN) pselw[idx] = 1'b1;
    #1 err_setup = PSLVERR;
    @(posedge PCLK); #1 PENABLE = 1; #1;
    waits = 0;
    while (PREADY !== 1'b1 && waits < 8) begin
      @(posedge PCLK); #2;
      waits++;
    end
    n_run++;
    if (PREADY !== 1'b1) begin
      n_fail++; $display("FAIL apb_pready_timeout: PREADY=%b, required 1", PREADY);
    end
    rdata = PRDATA; err = PSLVERR;
    if (rx_last) begin rx_valid = 1; rx_data = rxd; end
    @(posedge PCLK); #1;
    rx_valid = 0; PSEL = 0; PENABLE = 0; PWRITE = 0; pselw = '0;
    #1 err_after = PSLVERR;
  endtask

  task automatic pulse_rx(input logic [7:0] d);
    @(posedge PCLK); #1 rx_valid = 1; rx_data = d;
    @(posedge PCLK); #1 rx_valid = 0;
    if (m_rxv) m_ovr = 1;
    m_rxv = 1; m_rx = d;
  endtask

  task automatic pulse_tx();
    @(posedge PCLK); #1 tx_ready = 1;
    @(posedge PCLK); #1 tx_ready = 0;
    m_txfull = 0;
  endtask

  task automatic test_reset();
    PRESET = 1;
    repeat (3) @(posedge PCLK);
    #1;
    n_run++; if (PREADY !== 1'b1)  begin n_fail++; $display("FAIL rst_pready: got %b, required 1", PREADY); end
    n_run++; if (PSLVERR !== 1'b0) begin n_fail++; $display("FAIL rst_pslverr: got %b, required 0", PSLVERR); end
    n_run++; if (PRDATA !== 32'd0) begin n_fail++; $display("FAIL rst_prdata: got %h, required 0", PRDATA); end
    n_run++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL rst_tx_valid: got %b, required 0", tx_valid); end
    n_run++; if (irq !== 1'b0)     begin n_fail++; $display("FAIL rst_irq: got %b, required 0", irq); end
    n_run++; if (cfg_div !== 16'd1) begin n_fail++; $display("FAIL rst_cfg_div: got %h, required 1", cfg_div); end
    PRESET = 0;
    model_reset();
    for (int i = 0; i < 5; i++) begin
      apb(0, i, 0, 0, 0, rd, e, es, ea, w);
      n_run++; if (rd !== ((i == 1) ? 32'd1 : 32'd0)) begin n_fail++; $display("FAIL rst_read_%0d: got %h, required %h", i, rd, (i == 1) ? 32'd1 : 32'd0); end
      n_run++; if (e !== 1'b0) begin n_fail++; $display("FAIL rst_read_err_%0d: got %b, required 0", i, e); end
    end
  endtask

  task automatic test_clkdiv();
    logic [15:0] vals [3];
    vals[0] = 16'h0000; vals[1] = 16'h0010; vals[2] = 16'($urandom_range(1, 16'hFFFF));
    for (int i = 0; i < 3; i++) begin
      apb(1, 1, {16'hDEAD, vals[i]}, 0, 0, rd, e, es, ea, w);
      model_apply(1, 1, {16'hDEAD, vals[i]}, 0, 0);
      n_run++; if (cfg_div !== m_div) begin n_fail++; $display("FAIL clkdiv_cfg_%0d: got %h, required %h", i, cfg_div, m_div); end
      apb(0, 1, 0, 0, 0, rd, e, es, ea, w);
      n_run++; if (rd !== model_read(1)) begin n_fail++; $display("FAIL clkdiv_read_%0d: got %h, required %h", i, rd, model_read(1)); end
    end
  endtask

  task automatic test_tx();
    apb(1, 2, 32'hA5, 0, 0, rd, e, es, ea, w);
    model_apply(1, 2, 32'hA5, 0, 0);
    n_run++; if (e !== 1'b0) begin n_fail++; $display("FAIL tx_first_err: got %b, required 0", e); end
    n_run++; if ({tx_valid, tx_data} !== 9'h1A5) begin n_fail++; $display("FAIL tx_first: got %b/%h, required 1/a5", tx_valid, tx_data); end
    apb(1, 2, 32'h3C, 0, 0, rd, e, es, ea, w);
    n_run++; if ({es, e, ea} !== 3'b010) begin n_fail++; $display("FAIL tx_full_err: setup/access/after %b%b%b, required 010", es, e, ea); end
    n_run++; if (tx_data !== 8'hA5) begin n_fail++; $display("FAIL tx_full_data: got %h, required a5", tx_data); end
    apb(0, 2, 0, 0, 0, rd, e, es, ea, w);
    n_run++; if (rd !== 32'd0) begin n_fail++; $display("FAIL tx_read_zero: got %h, required 0", rd); end
    apb(0, 4, 0, 0, 0, rd, e, es, ea, w);
    n_run++; if (rd !== 32'h2) begin n_fail++; $display("FAIL tx_status_full: got %h, required 2", rd); end
    pulse_tx();
    n_run++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL tx_handshake: got %b, required 0", tx_valid); end
  endtask

  task automatic test_rx();
    pulse_rx(8'h11);
    pulse_rx(8'h22);
    apb(0, 4, 0, 0, 0, rd, e, es, ea, w);
    n_run++; if (rd !== 32'h0C) begin n_fail++; $display("FAIL rx_status_ovr: got %h, required 0c", rd); end
    apb(0, 3, 0, 0, 0, rd, e, es, ea, w);
    model_apply(0, 3, 0, 0, 0);
    n_run++; if (w !== 1) begin n_fail++; $display("FAIL rx_wait_states: got %0d, required 1", w); end
    n_run++; if (rd !== 32'h22) begin n_fail++; $display("FAIL rx_read_data: got %h, required 22", rd); end
    apb(0, 4, 0, 0, 0, rd, e, es, ea, w);
    n_run++; if (rd !== 32'h08) begin n_fail++; $display("FAIL rx_status_after: got %h, required 08", rd); end
    apb(1, 4, 32'h08, 0, 0, rd, e, es, ea, w);
    model_apply(1, 4, 32'h08, 0, 0);
    apb(0, 4, 0, 0, 0, rd, e, es, ea, w);
    n_run++; if (rd !== 32'h00) begin n_fail++; $display("FAIL rx_w1c: got %h, required 00", rd); end
  endtask

  task automatic test_errors();
    apb(1, 3, 32'h55, 0, 0, rd, e, es, ea, w);
    n_run++; if ({es, e, ea} !== 3'b010) begin n_fail++; $display("FAIL err_rxwrite: setup/access/after %b%b%b, required 010", es, e, ea); end
    apb(0, 3, 0, 0, 0, rd, e, es, ea, w);
    model_apply(0, 3, 0, 0, 0);
    n_run++; if (rd !== model_read(3)) begin n_fail++; $display("FAIL err_rx_unchanged: got %h, required %h", rd, model_read(3)); end
    dec_err = 1;
    apb(1, -1, 32'hFFFF_FFFF, 0, 0, rd, e, es, ea, w);
    n_run++; if ({es, e, ea} !== 3'b010) begin n_fail++; $display("FAIL err_decode: setup/access/after %b%b%b, required 010", es, e, ea); end
    dec_err = 0;
    apb(0, 0, 0, 0, 0, rd, e, es, ea, w);
    n_run++; if (rd !== model_read(0)) begin n_fail++; $display("FAIL err_ctrl_unchanged: got %h, required %h", rd, model_read(0)); end
    n_run++; if (cfg_div !== m_div) begin n_fail++; $display("FAIL err_div_unchanged: got %h, required %h", cfg_div, m_div); end
  endtask

  task automatic test_races();
    pulse_rx(8'h33);
    apb(0, 3, 0, 1, 8'h44, rd, e, es, ea, w);
    model_apply(0, 3, 0, 1, 8'h44);
    n_run++; if (rd !== 32'h33) begin n_fail++; $display("FAIL race_rd_old: got %h, required 33", rd); end
    apb(0, 4, 0, 0, 0, rd, e, es, ea, w);
    n_run++; if (rd !== model_read(4)) begin n_fail++; $display("FAIL race_rxv_kept: got %h, required %h", rd, model_read(4)); end
    apb(1, 4, 32'h08, 1, 8'h55, rd, e, es, ea, w);
    model_apply(1, 4, 32'h08, 1, 8'h55);
    apb(0, 4, 0, 0, 0, rd, e, es, ea, w);
    n_run++; if (rd !== model_read(4)) begin n_fail++; $display("FAIL race_w1c_vs_set: got %h, required %h", rd, model_read(4)); end
    apb(0, 3, 0, 0, 0, rd, e, es, ea, w);
    n_run++; if (rd !== 32'h55) begin n_fail++; $display("FAIL race_rd_new: got %h, required 55", rd); end
    model_apply(0, 3, 0, 0, 0);
  endtask

  task automatic test_irq();
    test_reset();
    apb(1, 0, 32'h11, 0, 0, rd, e, es, ea, w);
    model_apply(1, 0, 32'h11, 0, 0);
    repeat (2) @(posedge PCLK);
    #1;
    n_run++; if (irq !== IRQ_FEAT) begin n_fail++; $display("FAIL irq_tx_empty: got %b, required %b", irq, IRQ_FEAT); end
    apb(0, 0, 0, 0, 0, rd, e, es, ea, w);
    n_run++; if (rd !== model_read(0)) begin n_fail++; $display("FAIL irq_ctrl_read: got %h, required %h", rd, model_read(0)); end
    apb(1, 2, 32'h5A, 0, 0, rd, e, es, ea, w);
    model_apply(1, 2, 32'h5A, 0, 0);
    @(posedge PCLK); #1;
    n_run++; if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_tx_full: got %b, required 0", irq); end
    pulse_rx(8'h77);
    @(posedge PCLK); #1;
    n_run++; if (irq !== IRQ_FEAT) begin n_fail++; $display("FAIL irq_rx: got %b, required %b", irq, IRQ_FEAT); end
  endtask

  task automatic test_random();
    int op, idx;
    logic [31:0] d, exp;
    bit rxl, exp_err;
    logic [7:0] rxd;
    for (int it = 0; it < 150; it++) begin
      op = $urandom_range(0, 6);
      d = $urandom;
      rxd = 8'($urandom);
      rxl = ($urandom_range(0, 3) == 0);
      busy = 1'($urandom_range(0, 1));
      case (op)
        0, 1, 2, 6: begin
          idx = (op == 6) ? (($urandom_range(0, 1) == 0) ? 4 : 3) : op;
          if (op == 1 && $urandom_range(0, 3) == 0) d[15:0] = 16'd0;
          exp_err = model_err(1, idx);
          apb(1, idx, d, rxl, rxd, rd, e, es, ea, w);
          model_apply(1, idx, d, rxl, rxd);
          n_run++; if (e !== exp_err) begin n_fail++; $display("FAIL rnd_wr_err it%0d reg%0d: got %b, required %b", it, idx, e, exp_err); end
        end
        3: if (m_en && m_txfull) pulse_tx();
        4: pulse_rx(rxd);
        default: begin
          idx = $urandom_range(0, 4);
          exp = model_read(idx);
          apb(0, idx, 0, rxl, rxd, rd, e, es, ea, w);
          model_apply(0, idx, 0, rxl, rxd);
          n_run++; if (rd !== exp) begin n_fail++; $display("FAIL rnd_read it%0d reg%0d: got %h, required %h", it, idx, rd, exp); end
          n_run++; if (w !== ((idx == 3) ? 1 : 0)) begin n_fail++; $display("FAIL rnd_waits it%0d reg%0d: got %0d, required %0d", it, idx, w, (idx == 3) ? 1 : 0); end
        end
      endcase
      @(posedge PCLK); #1;
      n_run++;
      if ({tx_valid, cfg_en, cfg_cpol, cfg_cpha, cfg_div} !== {m_txfull, m_en, m_cpol, m_cpha, m_div} ||
          (m_txfull && tx_data !== m_tx)) begin
        n_fail++; $display("FAIL rnd_outputs it%0d: got v%b e%b p%b h%b div%h tx%h, required v%b e%b p%b h%b div%h tx%h",
          it, tx_valid, cfg_en, cfg_cpol, cfg_cpha, cfg_div, tx_data, m_txfull, m_en, m_cpol, m_cpha, m_div, m_tx);
      end
      n_run++;
      if (irq !== (IRQ_FEAT & m_irqen & (m_rxv | m_ovr | !m_txfull))) begin
        n_fail++; $display("FAIL rnd_irq it%0d: got %b, required %b", it, irq, IRQ_FEAT & m_irqen & (m_rxv | m_ovr | !m_txfull));
      end
    end
  endtask

  task automatic test_reset_abort();
    @(posedge PCLK); #1;
    PSEL = 1; PENABLE = 0; PWRITE = 0; pselw = 5'b01000;
    @(posedge PCLK); #1 PENABLE = 1; #1;
    n_run++; if (PREADY !== 1'b0) begin n_fail++; $display("FAIL abort_wait: got %b, required 0", PREADY); end
    PRESET = 1; PSEL = 0; PENABLE = 0; pselw = '0;
    @(posedge PCLK); #1 PRESET = 0;
    model_reset();
    #1;
    n_run++; if ({PREADY, PSLVERR, tx_valid, PRDATA} !== {3'b100, 32'd0}) begin
      n_fail++; $display("FAIL abort_state: got %b%b%b/%h, required 100/0", PREADY, PSLVERR, tx_valid, PRDATA);
    end
    apb(0, 1, 0, 0, 0, rd, e, es, ea, w);
    n_run++; if (rd !== 32'd1) begin n_fail++; $display("FAIL abort_clkdiv: got %h, required 1", rd); end
  endtask

  initial begin
    test_reset();
    test_clkdiv();
    test_tx();
    test_rx();
    test_errors();
    test_races();
    test_irq();
    test_random();
    test_reset_abort();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
